// File: rtl/fwd_mux_pipe.sv
// fwd_mux_pipe: registered N-input forwarding mux with valid/ready handshake and two-entry skid buffer
// Ports: clk/rst_n (async active-low); data_in (NUM_IN lanes of WIDTH), sel, in_valid -> in_ready;
//        out_data/out_sel/out_valid <- out_ready; flush drops contents; sel_err pulse, err_count saturating.
module fwd_mux_pipe #(
  parameter int WIDTH = 8,
  parameter int NUM_IN = 3,
  parameter int SEL_W = 2,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flush,
  output logic                    sel_err,
  output logic [7:0]              err_count
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] s_data, mux_data;
  logic [SEL_W-1:0] s_sel;
  logic accept, drain, bad;
  always_comb begin
    mux_data = DEFAULT_VAL;
    bad = 1'b1;
    for (int k = 0; k < NUM_IN; k++)
      if (sel == SEL_W'(k)) begin
        mux_data = data_in[k*WIDTH +: WIDTH];
        bad = 1'b0;
      end
  end
  assign accept = in_valid && in_ready && !flush;
  assign drain = out_valid && out_ready;
  always_comb
    state_nx = flush ? EMPTY :
               state == EMPTY ? (accept ? ONE : EMPTY) :
               state == ONE ? (accept && !drain ? FULL : !accept && drain ? EMPTY : ONE) :
               (drain ? ONE : FULL);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= EMPTY;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
      s_data <= '0;
      s_sel <= '0;
      sel_err <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_nx;
      in_ready <= state_nx != FULL;
      out_valid <= state_nx != EMPTY;
      if (accept && (state == EMPTY || (state == ONE && drain))) begin
        out_data <= mux_data;
        out_sel <= sel;
      end else if (state == FULL && drain) begin
        out_data <= s_data;
        out_sel <= s_sel;
      end
      if (accept && state == ONE && !drain) begin
        s_data <= mux_data;
        s_sel <= sel;
      end
      sel_err <= accept && bad;
      if (accept && bad && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
endmodule

// File: tb/tb_fwd_mux_pipe.sv
// tb_fwd_mux_pipe: scoreboard bench for fwd_mux_pipe at two parameter sets
module tb_fwd_mux_pipe;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  logic [23:0] a_din = '0;
  logic [1:0] a_sel = '0, a_osel;
  logic a_iv = 0, a_ir, a_ov, a_or = 0, a_fl = 0, a_err;
  logic [7:0] a_odata, a_cnt;

  logic [159:0] b_din = '0;
  logic [2:0] b_sel = '0, b_osel;
  logic b_iv = 0, b_ir, b_ov, b_or = 0, b_fl = 0, b_err;
  logic [31:0] b_odata;
  logic [7:0] b_cnt;

  fwd_mux_pipe dut_a (.clk(clk), .rst_n(rst_n), .data_in(a_din), .sel(a_sel), .in_valid(a_iv),
    .in_ready(a_ir), .out_data(a_odata), .out_sel(a_osel), .out_valid(a_ov), .out_ready(a_or),
    .flush(a_fl), .sel_err(a_err), .err_count(a_cnt));

  fwd_mux_pipe #(.WIDTH(32), .NUM_IN(5), .SEL_W(3), .DEFAULT_VAL(32'hDEAD_BEEF)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(b_din), .sel(b_sel), .in_valid(b_iv),
    .in_ready(b_ir), .out_data(b_odata), .out_sel(b_osel), .out_valid(b_ov), .out_ready(b_or),
    .flush(b_fl), .sel_err(b_err), .err_count(b_cnt));

  int checks = 0, errors = 0;
  logic [9:0] qa[$];
  logic [34:0] qb[$];
  logic ea = 0, eb = 0;
  int ca = 0, cb = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick_a();
    logic acc, drn, bad;
    logic [9:0] exp;
    acc = a_iv && qa.size() < 2 && !a_fl;
    drn = qa.size() > 0 && a_or;
    bad = a_sel >= 2'd3;
    if (drn) begin
      exp = qa.pop_front();
      checks++;
      if ({a_osel, a_odata} !== exp) begin
        errors++;
        $display("FAIL a_drain: got sel=%0d data=%h, want sel=%0d data=%h", a_osel, a_odata, exp[9:8], exp[7:0]);
      end
    end
    if (a_fl) qa.delete();
    else if (acc) qa.push_back({a_sel, bad ? 8'h00 : a_din[a_sel*8 +: 8]});
    ea = acc && bad;
    if (ea && ca != 255) ca++;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_ov, a_ir, a_err, a_cnt} !== {qa.size() > 0, qa.size() < 2, ea, 8'(ca)}) begin
      errors++;
      $display("FAIL a_status: got ov=%b ir=%b err=%b cnt=%0d, want ov=%b ir=%b err=%b cnt=%0d",
        a_ov, a_ir, a_err, a_cnt, qa.size() > 0, qa.size() < 2, ea, ca);
    end
  endtask

  task automatic tick_b();
    logic acc, drn, bad;
    logic [34:0] exp;
    acc = b_iv && qb.size() < 2 && !b_fl;
    drn = qb.size() > 0 && b_or;
    bad = b_sel >= 3'd5;
    if (drn) begin
      exp = qb.pop_front();
      checks++;
      if ({b_osel, b_odata} !== exp) begin
        errors++;
        $display("FAIL b_drain: got sel=%0d data=%h, want sel=%0d data=%h", b_osel, b_odata, exp[34:32], exp[31:0]);
      end
    end
    if (b_fl) qb.delete();
    else if (acc) qb.push_back({b_sel, bad ? 32'hDEAD_BEEF : b_din[b_sel*32 +: 32]});
    eb = acc && bad;
    if (eb && cb != 255) cb++;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({b_ov, b_ir, b_err, b_cnt} !== {qb.size() > 0, qb.size() < 2, eb, 8'(cb)}) begin
      errors++;
      $display("FAIL b_status: got ov=%b ir=%b err=%b cnt=%0d, want ov=%b ir=%b err=%b cnt=%0d",
        b_ov, b_ir, b_err, b_cnt, qb.size() > 0, qb.size() < 2, eb, cb);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({a_ov, a_ir, a_odata, a_osel, a_err, a_cnt} !== {1'b0, 1'b1, 8'h00, 2'd0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_state: got ov=%b ir=%b data=%h sel=%0d err=%b cnt=%0d, want 0 1 00 0 0 0",
        a_ov, a_ir, a_odata, a_osel, a_err, a_cnt);
    end
    rst_n = 1;
    tick_a();
  endtask

  task automatic test_basic();
    a_din = {8'hC3, 8'hB2, 8'hA1};
    a_or = 1;
    a_iv = 1;
    for (int i = 0; i < 3; i++) begin
      a_sel = 2'(i);
      tick_a();
    end
    a_iv = 0;
    tick_a();
  endtask

  task automatic test_out_of_range();
    a_sel = 2'd3;
    a_iv = 1;
    tick_a();
    a_iv = 0;
    tick_a();
    a_iv = 1;
    repeat (300) tick_a();
    a_iv = 0;
    tick_a();
    checks++;
    if (a_cnt !== 8'd255) begin
      errors++;
      $display("FAIL err_saturate: got %0d, want 255", a_cnt);
    end
  endtask

  task automatic test_backpressure();
    a_or = 0;
    a_sel = 0;
    a_iv = 1;
    a_din[7:0] = 8'h11;
    tick_a();
    a_din[7:0] = 8'h22;
    tick_a();
    a_din[7:0] = 8'h33;
    repeat (2) tick_a();
    a_or = 1;
    repeat (2) tick_a();
    a_iv = 0;
    repeat (2) tick_a();
  endtask

  task automatic test_flush_full();
    a_or = 0;
    a_sel = 1;
    a_iv = 1;
    repeat (2) tick_a();
    a_fl = 1;
    a_or = 1;
    a_sel = 3;
    tick_a();
    a_fl = 0;
    a_iv = 0;
    tick_a();
  endtask

  task automatic test_async_reset();
    a_or = 0;
    a_sel = 2;
    a_iv = 1;
    repeat (2) tick_a();
    a_iv = 0;
    #2 rst_n = 0;
    #1;
    checks++;
    if ({a_ov, a_odata, a_ir, a_cnt} !== {1'b0, 8'h00, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL async_reset: got ov=%b data=%h ir=%b cnt=%0d, want 0 00 1 0", a_ov, a_odata, a_ir, a_cnt);
    end
    qa.delete();
    qb.delete();
    ca = 0;
    cb = 0;
    ea = 0;
    eb = 0;
    @(negedge clk);
    rst_n = 1;
    a_or = 1;
    tick_a();
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 600; i++) begin
      b_din = {$urandom, $urandom, $urandom, $urandom, $urandom};
      b_sel = 3'($urandom_range(0, 7));
      b_iv = $urandom_range(0, 3) != 0;
      b_or = $urandom_range(0, 3) != 0;
      b_fl = $urandom_range(0, 31) == 0;
      tick_b();
    end
    b_iv = 0;
    b_fl = 0;
    b_or = 1;
    repeat (3) tick_b();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_out_of_range();
    test_backpressure();
    test_flush_full();
    test_async_reset();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
